// File: rtl/serial_adder_pkg.sv
// Shared ALU encodings for the serial adder/subtractor:
// op codes, FSM states and the {Z,N,C,V} status-flag packing.
package serial_adder_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit order matches the status register: {Z,N,C,V}.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  // Subtraction is a + ~b + carry; op[1] selects it.
  function automatic logic op_is_sub(
    input logic [1:0] op
  );
    return op[1];
  endfunction

  // Initial carry: fixed for ADD/SUB, caller's cin for ADC/SBC.
  function automatic logic op_k0(
    input logic [1:0] op,
    input logic       cin
  );
    logic k;
    k = 1'b0;
    unique case (op)
      OP_ADD:  k = 1'b0;
      OP_ADC:  k = cin;
      OP_SUB:  k = 1'b1;
      OP_SBC:  k = cin;
      default: k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-wide combinational ripple adder for one serial step.
// Ports: x, y operand digits; ci carry in; s digit sum; co carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] cc;

  assign cc[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (cc[i]),
      .s  (s[i]),
      .co (cc[i+1])
    );
  end

  assign co = cc[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle ADD/ADC/SUB/SBC, DIGIT bits per clock, LSB first.
// Ports: clk, rst_n; in_valid/in_ready + a, b, cin, op;
//        out_valid/out_ready + sum and z, n, c, v flags.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             k_q, k_d;
  logic             zacc_q, zacc_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  flags_t           flg_q, flg_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_zero;
  logic [WIDTH-1:0] b_eff;

  // Widened copies so the shift works for DIGIT == WIDTH too.
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH+DIGIT-1:0] a_cat;
  logic [WIDTH+DIGIT-1:0] b_cat;

  logic is_idle, is_run, is_done;

  assign is_idle = (state_q == ST_IDLE);
  assign is_run  = (state_q == ST_RUN);
  assign is_done = (state_q == ST_DONE);

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_dig (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (k_q),
    .s  (dig_s),
    .co (dig_co)
  );

  assign dig_zero = (dig_s == '0);
  assign b_eff    = op_is_sub(op) ? ~b : b;
  assign sum_cat  = {dig_s, sum_q};
  assign a_cat    = {{DIGIT{1'b0}}, a_q};
  assign b_cat    = {{DIGIT{1'b0}}, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    zacc_d  = zacc_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    flg_d   = flg_q;
    unique case (1'b1)
      is_idle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          k_d     = op_k0(op, cin);
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b_eff[WIDTH-1];
          cnt_d   = '0;
          zacc_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      is_run: begin
        sum_d  = sum_cat[WIDTH+DIGIT-1:DIGIT];
        a_d    = a_cat[WIDTH+DIGIT-1:DIGIT];
        b_d    = b_cat[WIDTH+DIGIT-1:DIGIT];
        k_d    = dig_co;
        zacc_d = zacc_q & dig_zero;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final digit holds the result MSB.
          flg_d.c = dig_co;
          flg_d.n = dig_s[DIGIT-1];
          flg_d.z = zacc_q & dig_zero;
          flg_d.v = (amsb_q ~^ bmsb_q)
                  & (amsb_q ^ dig_s[DIGIT-1]);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      is_done: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= 1'b0;
      zacc_q  <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      zacc_q  <= zacc_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      flg_q   <= flg_d;
    end
  end

  assign in_ready  = is_idle;
  assign out_valid = is_done;
  assign sum       = sum_q;
  assign z         = flg_q.z;
  assign n         = flg_q.n;
  assign c         = flg_q.c;
  assign v         = flg_q.v;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT = 4, 16 and 1 instances,
// vector table, random ops, backpressure and mid-run reset.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk;
  logic rst_n;
  logic [15:0] a, b;
  logic cin;
  logic [1:0] op;
  logic [2:0] iv, ir, ov, ordy;
  logic [2:0] fz, fn, fc, fv;
  logic [2:0][15:0] sm;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic [3:0]  flg;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  flg;
  } res_t;

  vec_t tbl[10];
  res_t sb[$];
  int   lat[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sm[0]), .z(fz[0]), .n(fn[0]),
    .c(fc[0]), .v(fv[0])
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sm[1]), .z(fz[1]), .n(fn[1]),
    .c(fc[1]), .v(fv[1])
  );

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(sm[2]), .z(fz[2]), .n(fn[2]),
    .c(fc[2]), .v(fv[2])
  );

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_of(input int k);
    return {fz[k], fn[k], fc[k], fv[k]};
  endfunction

  function automatic res_t model(
    input logic [1:0]  o,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci
  );
    res_t r;
    logic [15:0] yy;
    logic [16:0] full;
    logic k;
    yy = (o == OP_SUB || o == OP_SBC) ? ~y : y;
    if (o == OP_ADD) k = 1'b0;
    else if (o == OP_SUB) k = 1'b1;
    else k = ci;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, k};
    r.sum = full[15:0];
    r.flg = {r.sum == 16'd0, r.sum[15], full[16],
             (x[15] == yy[15]) && (x[15] != r.sum[15])};
    return r;
  endfunction

  task automatic run_op(
    input int          k,
    input logic [1:0]  op_i,
    input logic [15:0] a_i,
    input logic [15:0] b_i,
    input logic        cin_i,
    input res_t        e,
    input int          hold
  );
    res_t got;
    int cyc;
    check("in_ready_idle", 32'(ir[k]), 32'd1);
    a = a_i; b = b_i; op = op_i; cin = cin_i;
    iv[k] = 1'b1;
    ordy[k] = 1'b0;
    @(posedge clk); #1;
    sb.push_back(e);
    iv[k] = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    op = 2'($urandom); cin = 1'($urandom);
    cyc = 1;
    check("in_ready_busy", 32'(ir[k]), 32'd0);
    while (!ov[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat[k]));
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty expected entry");
      return;
    end
    got = sb.pop_front();
    check("sum", 32'(sm[k]), 32'(got.sum));
    check("flags", 32'(flags_of(k)), 32'(got.flg));
    for (int i = 0; i < hold; i++) begin
      iv[k] = ~iv[k];
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check("bp_valid", 32'(ov[k]), 32'd1);
      check("bp_ready", 32'(ir[k]), 32'd0);
      check("bp_sum", 32'(sm[k]), 32'(got.sum));
      check("bp_flags", 32'(flags_of(k)), 32'(got.flg));
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check("drop_valid", 32'(ov[k]), 32'd0);
    check("back_idle", 32'(ir[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    res_t e;
    lat[0] = 5; lat[1] = 2; lat[2] = 17;
    tbl[0] = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101};
    tbl[1] = '{OP_SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b1010};
    tbl[2] = '{OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1010};
    tbl[3] = '{OP_SBC, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011};
    tbl[4] = '{OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 4'b0000};
    tbl[5] = '{OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b0100};
    tbl[6] = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b1010};
    tbl[7] = '{OP_SBC, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0010};
    tbl[8] = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011};
    tbl[9] = '{OP_ADC, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1011};

    rst_n = 1'b0;
    iv = '0; ordy = '0;
    a = '0; b = '0; op = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(ir[k]), 32'd1);
      check("rst_valid", 32'(ov[k]), 32'd0);
      check("rst_sum", 32'(sm[k]), 32'd0);
      check("rst_flags", 32'(flags_of(k)), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        e.sum = tbl[i].sum;
        e.flg = tbl[i].flg;
        run_op(k, tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].cin, e, (i == 0) ? 3 : 0);
      end
      for (int i = 0; i < 6; i++) begin
        logic [1:0]  ro;
        logic [15:0] ra, rb;
        logic        rc;
        ro = 2'($urandom);
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        run_op(k, ro, ra, rb, rc, model(ro, ra, rb, rc), 1);
      end
    end

    // Mid-run reset on the DIGIT=4 instance.
    a = 16'h7FFF; b = 16'h0001; op = OP_ADD; cin = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(OP_ADD, 16'h7FFF, 16'h0001, 1'b0));
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ov[0]), 32'd0);
    check("mid_rst_ready", 32'(ir[0]), 32'd1);
    check("mid_rst_sum", 32'(sm[0]), 32'd0);
    check("mid_rst_flags", 32'(flags_of(0)), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    check("rst_hold_valid", 32'(ov[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    e.sum = 16'h0007;
    e.flg = 4'b0000;
    run_op(0, OP_ADD, 16'h0003, 16'h0004, 1'b0, e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
